// File: rtl/z80_ir_refresh_pkg.sv
// Shared Z80 definitions for the I/R refresh block.
// Holds the M1 T-state enumeration (also used by the z80fi tracer so both
// sides agree on the encoding), the refresh increment mask and the helper
// that advances the R register.
package z80_ir_refresh_pkg;

    // M1 cycle T-states; the numeric encoding is visible on the tstate port.
    typedef enum logic [2:0] {
        TS_IDLE = 3'd0,
        TS_T1   = 3'd1,
        TS_T2   = 3'd2,
        TS_T3   = 3'd3,
        TS_T4   = 3'd4
    } tstate_e;

    // Only the low seven bits of R count; bit 7 belongs to software.
    localparam logic [6:0] REFRESH_INC_MASK = 7'h7F;

    // Advance R by one refresh step: low seven bits wrap 127->0, bit 7 kept.
    function automatic logic [7:0] r_increment(input logic [7:0] r_value);
        logic [6:0] low_s;
        low_s = (r_value[6:0] + 7'd1) & REFRESH_INC_MASK;
        return {r_value[7], low_s};
    endfunction

endpackage

// File: rtl/z80_ir_refresh.sv
// Z80 I and R registers with the M1 refresh sequencer.
//
// Ports:
//   clk          - system clock, all state changes on its rising edge
//   reset        - asynchronous active-high reset
//   m1_start     - one-cycle pulse marking T1 of each opcode fetch
//   wait_req     - stretches T2 while high
//   ld_i_we      - LD I,A write strobe
//   ld_r_we      - LD R,A write strobe
//   wdata        - accumulator value for I/R writes
//   reg_i        - current I register
//   reg_r        - current R register
//   refresh_addr - {I, R} captured at the start of the refresh slot
//   rfsh         - refresh strobe, high during T3 and T4
//   tstate       - current M1 T-state (package encoding)
//   proto_err    - sticky flag: m1_start seen in T1, T2 or T3
//
// All outputs come straight from flops; register writes appear one cycle
// after their strobe with no bypass.
module z80_ir_refresh
    import z80_ir_refresh_pkg::*;
#(
    parameter logic [7:0] REG_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_start,
    input  logic        wait_req,
    input  logic        ld_i_we,
    input  logic        ld_r_we,
    input  logic [7:0]  wdata,
    output logic [7:0]  reg_i,
    output logic [7:0]  reg_r,
    output logic [15:0] refresh_addr,
    output logic        rfsh,
    output logic [2:0]  tstate,
    output logic        proto_err
);

    tstate_e     state_r;
    logic [7:0]  i_r;
    logic [7:0]  r_r;
    logic [15:0] addr_r;
    logic        rfsh_r;
    logic        err_r;

    logic        refresh_edge_s;
    logic        misplaced_m1_s;

    // Decode the T2->T3 edge and any fetch pulse arriving mid-fetch.
    always_comb begin
        refresh_edge_s = 1'b0;
        misplaced_m1_s = 1'b0;
        case (state_r)
            TS_T1: begin
                misplaced_m1_s = m1_start;
            end
            TS_T2: begin
                refresh_edge_s = ~wait_req;
                misplaced_m1_s = m1_start;
            end
            TS_T3: begin
                misplaced_m1_s = m1_start;
            end
            default: begin
                refresh_edge_s = 1'b0;
                misplaced_m1_s = 1'b0;
            end
        endcase
    end

    // M1 sequencer, I/R registers and refresh capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= TS_IDLE;
            i_r     <= REG_RESET;
            r_r     <= REG_RESET;
            addr_r  <= 16'h0000;
            rfsh_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            // rfsh is registered alongside the state so it is high exactly
            // while the state register holds T3 or T4.
            case (state_r)
                TS_IDLE: begin
                    rfsh_r <= 1'b0;
                    if (m1_start) begin
                        state_r <= TS_T1;
                    end else begin
                        state_r <= TS_IDLE;
                    end
                end
                TS_T1: begin
                    state_r <= TS_T2;
                    rfsh_r  <= 1'b0;
                end
                TS_T2: begin
                    if (wait_req) begin
                        state_r <= TS_T2;
                        rfsh_r  <= 1'b0;
                    end else begin
                        state_r <= TS_T3;
                        rfsh_r  <= 1'b1;
                    end
                end
                TS_T3: begin
                    state_r <= TS_T4;
                    rfsh_r  <= 1'b1;
                end
                TS_T4: begin
                    rfsh_r <= 1'b0;
                    if (m1_start) begin
                        state_r <= TS_T1;
                    end else begin
                        state_r <= TS_IDLE;
                    end
                end
                default: begin
                    state_r <= TS_IDLE;
                    rfsh_r  <= 1'b0;
                end
            endcase

            // The refresh address uses the values before this edge's update.
            if (refresh_edge_s) begin
                addr_r <= {i_r, r_r};
            end else begin
                addr_r <= addr_r;
            end

            if (ld_i_we) begin
                i_r <= wdata;
            end else begin
                i_r <= i_r;
            end

            // A software write to R wins over the refresh increment.
            if (ld_r_we) begin
                r_r <= wdata;
            end else if (refresh_edge_s) begin
                r_r <= r_increment(r_r);
            end else begin
                r_r <= r_r;
            end

            if (misplaced_m1_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign reg_i        = i_r;
    assign reg_r        = r_r;
    assign refresh_addr = addr_r;
    assign rfsh         = rfsh_r;
    assign tstate       = state_r;
    assign proto_err    = err_r;

endmodule

// File: tb/tb_z80_ir_refresh.sv
// Self-checking bench for z80_ir_refresh: directed scenarios followed by
// random stimulus, all compared against a cycle-level behavioural model.
module tb_z80_ir_refresh;

    logic        clk = 1'b0;
    logic        reset;
    logic        m1_start;
    logic        wait_req;
    logic        ld_i_we;
    logic        ld_r_we;
    logic [7:0]  wdata;
    logic [7:0]  reg_i;
    logic [7:0]  reg_r;
    logic [15:0] refresh_addr;
    logic        rfsh;
    logic [2:0]  tstate;
    logic        proto_err;

    z80_ir_refresh dut (
        .clk          (clk),
        .reset        (reset),
        .m1_start     (m1_start),
        .wait_req     (wait_req),
        .ld_i_we      (ld_i_we),
        .ld_r_we      (ld_r_we),
        .wdata        (wdata),
        .reg_i        (reg_i),
        .reg_r        (reg_r),
        .refresh_addr (refresh_addr),
        .rfsh         (rfsh),
        .tstate       (tstate),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int rfsh_cnt     = 0;
    int t2_cnt       = 0;

    // Reference model: phase is the position inside the fetch (0 = idle,
    // 1..4 = T1..T4), registers are plain integers/bytes.
    int          m_phase;
    logic [7:0]  m_i;
    logic [7:0]  m_r;
    logic [15:0] m_addr;
    bit          m_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_i     = 8'h00;
        m_r     = 8'h00;
        m_addr  = 16'h0000;
        m_err   = 1'b0;
    endtask

    // One clock edge worth of behaviour, using the values before the edge.
    task automatic model_step(input bit m1, input bit wt, input bit ldi, input bit ldr,
                              input logic [7:0] wd);
        int nxt;
        int low;
        bit refresh;
        refresh = (m_phase == 2) && !wt;
        if (m1 && m_phase >= 1 && m_phase <= 3) m_err = 1'b1;
        case (m_phase)
            0:       nxt = m1 ? 1 : 0;
            1:       nxt = 2;
            2:       nxt = wt ? 2 : 3;
            3:       nxt = 4;
            4:       nxt = m1 ? 1 : 0;
            default: nxt = 0;
        endcase
        if (refresh) begin
            m_addr = m_i * 256 + m_r;
            if (!ldr) begin
                low = (m_r % 128 + 1) % 128;
                m_r = 8'((m_r / 128) * 128 + low);
            end
        end
        if (ldi) m_i = wd;
        if (ldr) m_r = wd;
        m_phase = nxt;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".tstate"},    16'(tstate),    16'(m_phase));
        chk({ctx, ".rfsh"},      16'(rfsh),      16'(m_phase >= 3));
        chk({ctx, ".reg_i"},     16'(reg_i),     16'(m_i));
        chk({ctx, ".reg_r"},     16'(reg_r),     16'(m_r));
        chk({ctx, ".addr"},      refresh_addr,   m_addr);
        chk({ctx, ".proto_err"}, 16'(proto_err), 16'(m_err));
    endtask

    task automatic cyc(input bit m1, input bit wt, input bit ldi, input bit ldr,
                       input logic [7:0] wd);
        m1_start = m1;
        wait_req = wt;
        ld_i_we  = ldi;
        ld_r_we  = ldr;
        wdata    = wd;
        @(posedge clk);
        model_step(m1, wt, ldi, ldr, wd);
        #1;
        check_all("cyc");
        if (rfsh === 1'b1) rfsh_cnt++;
        if (tstate === 3'd2) t2_cnt++;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Complete fetch; the T1 pulse lands on T4 when chained after another.
    task automatic fetch(input int waits);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        for (int w = 0; w < waits; w++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        idle_cyc();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        m1_start = 1'b0;
        wait_req = 1'b0;
        ld_i_we  = 1'b0;
        ld_r_we  = 1'b0;
        wdata    = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        check_all("por");
        @(negedge clk);
        reset = 1'b0;

        // Three chained fetches: R 00->03, six refresh cycles.
        rfsh_cnt = 0;
        fetch(0);
        chk("bb1_addr", refresh_addr, 16'h0000);
        fetch(0);
        chk("bb2_addr", refresh_addr, 16'h0001);
        fetch(0);
        chk("bb3_addr", refresh_addr, 16'h0002);
        chk("bb_r", 16'(reg_r), 16'h0003);
        idle_cyc();
        chk("bb_rfsh_cycles", 16'(rfsh_cnt), 16'd6);

        // R=FF then one fetch: bit 7 kept, low bits wrap.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        chk("ldr_ff", 16'(reg_r), 16'h00FF);
        fetch(0);
        chk("wrap_addr", refresh_addr, 16'h00FF);
        chk("wrap_r", 16'(reg_r), 16'h0080);
        idle_cyc();

        // LD R on the T2->T3 edge suppresses the increment.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
        chk("ldr_prio_r", 16'(reg_r), 16'h0010);
        chk("ldr_prio_addr", refresh_addr, 16'h0080);
        idle_cyc();
        idle_cyc();

        // Three wait cycles: T2 spans four cycles, single increment.
        t2_cnt   = 0;
        rfsh_cnt = 0;
        fetch(3);
        chk("wait_t2_len", 16'(t2_cnt), 16'd4);
        chk("wait_r", 16'(reg_r), 16'h0011);
        chk("wait_rfsh", 16'(rfsh_cnt), 16'd2);
        idle_cyc();

        // Fetch pulse inside T2 is ignored and latches proto_err.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("perr_state", 16'(tstate), 16'd2);
        chk("perr_set", 16'(proto_err), 16'd1);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        idle_cyc();
        chk("perr_sticky", 16'(proto_err), 16'd1);
        chk("perr_r", 16'(reg_r), 16'h0012);

        // I write, R=05, fetch gives 3C05; then reset during T3.
        apply_reset();
        chk("perr_cleared", 16'(proto_err), 16'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        fetch(0);
        chk("ir_addr", refresh_addr, 16'h3C05);
        idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle_cyc();
        idle_cyc();
        chk("pre_rst_state", 16'(tstate), 16'd3);
        chk("pre_rst_r", 16'(reg_r), 16'h0007);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_t3_rfsh", 16'(rfsh), 16'd0);
        chk("rst_t3_r", 16'(reg_r), 16'h0000);
        chk("rst_t3_i", 16'(reg_i), 16'h0000);
        chk("rst_t3_state", 16'(tstate), 16'd0);
        model_reset();
        check_all("rst_t3");
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("first_edge_t1", 16'(tstate), 16'd1);
        idle_cyc();
        idle_cyc();
        idle_cyc();
        idle_cyc();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
